load_store_unit: RTL

//  Sequences datapath load/store requests onto the single-port, 16-bit-word data Memory.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/load_store_unit_if.sv | 36 +++
 rtl/lsu_byte_lane.sv | 28 ++
 rtl/load_store_unit.sv | 91 +++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, byte-lane selects,
// request latch layout and the per-operation completion latencies.
package lsu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_RD   = 3'd1;
  localparam state_t S_RDW  = 3'd2;
  localparam state_t S_WR   = 3'd3;
  localparam state_t S_RESP = 3'd4;

  localparam logic LANE_LO = 1'b0;  // bits [7:0]
  localparam logic LANE_HI = 1'b1;  // bits [15:8]

  // Accept edge to resp_valid cycle.
  localparam int LAT_WORD_LOAD  = 3;
  localparam int LAT_BYTE_LOAD  = 3;
  localparam int LAT_WORD_STORE = 2;
  localparam int LAT_BYTE_STORE = 4;
  localparam int LAT_MISALIGN   = 1;

  typedef struct packed {
    logic write;
    logic byte_acc;
    logic sign_ext;
    logic err;
  } req_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the Memory pin bundle of the load/store unit.
// master = execute stage + Memory side, slave = the unit itself.
interface load_store_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_byte;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;

  logic              mem_memR;
  logic              mem_memW;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dataW;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_memR, mem_memW, mem_addr, mem_dataW
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_memR, mem_memW, mem_addr, mem_dataW
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane helper: extracts/extends a byte from a word for loads
// and splices a byte into a word for read-modify-write stores.
module lsu_byte_lane #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] word,
  input  logic [7:0]        byte_in,
  input  logic              sel,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] extracted,
  output logic [DATA_W-1:0] merged
);
  localparam int NUM_LANES = DATA_W / 8;

  logic [NUM_LANES-1:0][7:0] lanes;
  logic [NUM_LANES-1:0][7:0] mrg_lanes;
  logic [7:0]                pick;

  assign lanes     = word;
  assign pick      = lanes[sel];
  assign extracted = {{(DATA_W-8){sign_ext & pick[7]}}, pick};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign mrg_lanes[i] = (sel == 1'(i)) ? byte_in : lanes[i];
  end

  assign merged = mrg_lanes;
endmodule

// File: rtl/load_store_unit.sv
// Sequences load/store requests onto a single-port 16-bit-word Memory:
// byte loads with extension, byte stores via read-modify-write, misalignment errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.slave  bus
);
  state_t            state, state_nx;
  req_t              rq;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;   // store word; becomes the merged word for byte stores
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ext_word, mrg_word;
  logic              accept, misalign;

  assign accept   = bus.req_valid && (state == S_IDLE);
  assign misalign = !bus.req_byte && bus.req_addr[0];

  lsu_byte_lane #(.DATA_W(DATA_W)) u_lane (
    .word      (bus.mem_rdata),
    .byte_in   (wdata_q[7:0]),
    .sel       (addr_q[0]),
    .sign_ext  (rq.sign_ext),
    .extracted (ext_word),
    .merged    (mrg_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.req_valid) begin
        if (misalign)                              state_nx = S_RESP;
        else if (!bus.req_write || bus.req_byte)   state_nx = S_RD;
        else                                       state_nx = S_WR;
      end
      S_RD:    state_nx = S_RDW;
      S_RDW:   state_nx = rq.write ? S_WR : S_RESP;
      S_WR:    state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latches and the read-capture point; req_* are only looked at in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq      <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        rq.write    <= bus.req_write;
        rq.byte_acc <= bus.req_byte;
        rq.sign_ext <= bus.req_signed;
        rq.err      <= misalign;
        addr_q      <= bus.req_addr;
        wdata_q     <= bus.req_wdata;
      end
      if (state == S_RDW) begin
        if (rq.write) wdata_q <= mrg_word;
        else          rdata_q <= rq.byte_acc ? ext_word : bus.mem_rdata;
      end
    end
  end

  always_comb begin
    bus.req_ready  = (state == S_IDLE);
    bus.resp_valid = (state == S_RESP);
    bus.resp_err   = (state == S_RESP) && rq.err;
    bus.resp_rdata = rdata_q;
    bus.mem_memR   = (state == S_RD);
    bus.mem_memW   = (state == S_WR);
    bus.mem_addr   = '0;
    bus.mem_dataW  = '0;
    if (state == S_RD || state == S_RDW || state == S_WR)
      bus.mem_addr = {1'b0, addr_q[ADDR_W-1:1]};
    if (state == S_WR)
      bus.mem_dataW = wdata_q;
  end
endmodule
